// File: rtl/pwm_pkg.sv
// Shared PWM definitions: frame geometry, demodulator state and the sample type used by the PWM output stage.
// No latency or backpressure of its own; the package holds only types and constants.
package pwm_pkg;
  localparam int PWM_DW        = 4;
  localparam int PWM_FRAME_LEN = 16;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  typedef logic [PWM_DW-1:0] sample_t;
endpackage

// File: rtl/pwmin_demod_if.sv
// Bundles the PWM input pair and the demodulator outputs (the stimulus side is master, the demod is slave).
// No latency or backpressure of its own; dout is qualified only by dout_valid.
interface pwmin_demod_if
  import pwm_pkg::*;
#(
  parameter int DW = $bits(sample_t)
);
  logic          pwm_in;
  logic          frame_sync;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          locked;
  logic          sync_err;

  modport master (output pwm_in, frame_sync, input dout, dout_valid, locked, sync_err);
  modport slave  (input pwm_in, frame_sync, output dout, dout_valid, locked, sync_err);
endinterface

// File: rtl/pwmin_sync.sv
// Equal-depth synchronizers for pwm and frame_sync. Latency is SYNC_STAGES, plus 1 with PWMIN_GLITCH_FILTER_EN (majority filter).
// No backpressure: one sample leaves every cycle.
module pwmin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  input  logic sync_i,
  output logic s_pwm_o,
  output logic s_sync_o
);
  logic [SYNC_STAGES-1:0] pwm_q;
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q  <= '0;
      sync_q <= '0;
    end else begin
      pwm_q  <= {pwm_q[SYNC_STAGES-2:0], pwm_i};
      sync_q <= {sync_q[SYNC_STAGES-2:0], sync_i};
    end
  end

`ifdef PWMIN_GLITCH_FILTER_EN
  logic [1:0] tap_q;
  logic       sync_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap_q      <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      tap_q      <= {tap_q[0], pwm_q[SYNC_STAGES-1]};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Vote is centred on tap_q[0], which lines up with the delayed sync.
  assign s_pwm_o  = (pwm_q[SYNC_STAGES-1] & tap_q[0]) |
                    (pwm_q[SYNC_STAGES-1] & tap_q[1]) |
                    (tap_q[0] & tap_q[1]);
  assign s_sync_o = sync_dly_q;
`else
  assign s_pwm_o  = pwm_q[SYNC_STAGES-1];
  assign s_sync_o = sync_q[SYNC_STAGES-1];
`endif
endmodule

// File: rtl/pwmin_demod.sv
// PWM-in demodulator: one saturated high-count per frame, dout_valid SYNC_STAGES+1 cycles after frame end (+1 with PWMIN_GLITCH_FILTER_EN).
// No backpressure: dout_valid is a single-cycle pulse, and dout holds its value until the next pulse.
module pwmin_demod
  import pwm_pkg::*;
#(
  parameter int DW          = PWM_DW,
  parameter int FRAME_LEN   = PWM_FRAME_LEN,
  parameter int SYNC_STAGES = 2,
  parameter int MISS_MAX    = 3
) (
  input  logic         MCLK,
  input  logic         MRST,
  pwmin_demod_if.slave bus
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
  localparam logic [MW-1:0] MISS_LIM = MW'(MISS_MAX);

  logic          s_pwm, s_sync;
  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [DW:0]   acc_q, acc_d, sum, s_pwm_ext;
  logic [MW-1:0] miss_q, miss_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          early_sync, miss_now, drop_lock;

  pwmin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (MCLK),
    .rst_i   (MRST),
    .pwm_i   (bus.pwm_in),
    .sync_i  (bus.frame_sync),
    .s_pwm_o (s_pwm),
    .s_sync_o(s_sync)
  );

  assign s_pwm_ext  = {{DW{1'b0}}, s_pwm};
  assign sum        = acc_q + s_pwm_ext;
  assign early_sync = s_sync && (pos_q != '0);
  assign miss_now   = !s_sync && (pos_q == '0);
  // A sync landing on the miss limit clears miss_now, so it keeps the lock.
  assign drop_lock  = miss_now && ((miss_q + MW'(1)) == MISS_LIM);

  always_ff @(posedge MCLK) begin
    if (MRST) state_q <= ST_UNLOCKED;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (s_sync)    state_d = ST_LOCKED;
      ST_LOCKED:   if (drop_lock) state_d = ST_UNLOCKED;
      default:                    state_d = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    pos_d   = pos_q;
    acc_d   = acc_q;
    miss_d  = miss_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (s_sync) begin
          pos_d  = PW'(1);
          acc_d  = s_pwm_ext;
          miss_d = '0;
        end
      end
      ST_LOCKED: begin
        if (early_sync) begin
          // Realign on the new strobe; the partial frame is dropped.
          err_d  = 1'b1;
          pos_d  = PW'(1);
          acc_d  = s_pwm_ext;
          miss_d = '0;
        end else if (drop_lock) begin
          pos_d  = '0;
          acc_d  = '0;
          miss_d = '0;
        end else begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
          if (s_sync)        miss_d = '0;
          else if (miss_now) miss_d = miss_q + MW'(1);
          if (pos_q == POS_LAST) begin
            acc_d   = '0;
            valid_d = 1'b1;
            dout_d  = sum[DW] ? '1 : sum[DW-1:0];
          end else begin
            acc_d = sum;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (MRST) begin
      pos_q   <= '0;
      acc_q   <= '0;
      miss_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      acc_q   <= acc_d;
      miss_q  <= miss_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.locked     = (state_q == ST_LOCKED);
  assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_pwmin_demod.sv
// Bench for pwmin_demod: directed frames checked against a frame-level model and hand-computed pulse values.
// The model works on the input timeline and is compared with the DUT outputs D cycles later.
module tb_pwmin_demod;
  import pwm_pkg::*;

  localparam int SS = 2;
`ifdef PWMIN_GLITCH_FILTER_EN
  localparam int D = SS + 1;
  localparam bit FILT = 1'b1;
`else
  localparam int D = SS;
  localparam bit FILT = 1'b0;
`endif
  localparam int FL = PWM_FRAME_LEN;
  localparam int NH = 2048;

  logic MCLK = 1'b0;
  logic MRST;
  pwmin_demod_if bus ();

  pwmin_demod #(.DW(PWM_DW), .FRAME_LEN(FL), .SYNC_STAGES(SS), .MISS_MAX(3)) dut (
    .MCLK(MCLK),
    .MRST(MRST),
    .bus (bus)
  );

  always #5 MCLK = ~MCLK;

  int cyc = 0;
  bit pwm_h[NH];
  bit sync_h[NH];
  bit rst_h[NH];
  int n_cmp = 0;
  int n_err = 0;
  int pq_cyc[$];
  int pq_val[$];
  int eq_cyc[$];

  bit mlock = 1'b0;
  int anchor = 0;
  int last_sync = 0;
  int hold = 0;

  always @(posedge MCLK) begin
    cyc = cyc + 1;
    if (cyc < NH) begin
      pwm_h[cyc]  = bus.pwm_in;
      sync_h[cyc] = bus.frame_sync;
      rst_h[cyc]  = MRST;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // An input cycle is lost if a reset edge hits it anywhere on its way to the FSM.
  function automatic bit flushed(input int k, input int lim);
    for (int j = k; j <= k + D && j <= lim; j++)
      if (j >= 1 && j < NH && rst_h[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int eff(input int k, input int lim);
    if (k < 1 || k >= NH || k > lim) return 0;
    return (flushed(k, lim) || !pwm_h[k]) ? 0 : 1;
  endfunction

  function automatic int filt(input int k, input int lim);
    if (FILT) return ((eff(k-1, lim) + eff(k, lim) + eff(k+1, lim)) >= 2) ? 1 : 0;
    return eff(k, lim);
  endfunction

  always @(negedge MCLK) begin
    int m, n, ph, s;
    bit ev, ee;
    m  = cyc;
    ev = 1'b0;
    ee = 1'b0;
    if (m >= 1 && m < NH) begin
      if (rst_h[m]) hold = 0;
      n = m - D;
      if (n >= 1) begin
        if (flushed(n, m)) begin
          mlock = 1'b0;
        end else if (!mlock) begin
          if (sync_h[n]) begin
            mlock = 1'b1;
            anchor = n;
            last_sync = n;
          end
        end else begin
          ph = (n - anchor) % FL;
          if (sync_h[n] && ph != 0) begin
            ee = 1'b1;
            anchor = n;
            last_sync = n;
          end else if (ph == 0 && !sync_h[n] && (n - last_sync) / FL >= 3) begin
            mlock = 1'b0;
          end else begin
            if (sync_h[n]) last_sync = n;
            if (ph == FL - 1) begin
              s = 0;
              for (int k = n - FL + 1; k <= n; k++) s += filt(k, m);
              ev = 1'b1;
              hold = (s > 15) ? 15 : s;
            end
          end
        end
      end
      chk("dout_valid", bus.dout_valid, ev);
      chk("dout", bus.dout, hold);
      chk("locked", bus.locked, mlock);
      chk("sync_err", bus.sync_err, ee);
      if (bus.dout_valid === 1'b1) begin
        pq_cyc.push_back(m);
        pq_val.push_back(int'(bus.dout));
      end
      if (bus.sync_err === 1'b1) eq_cyc.push_back(m);
    end
  end

  function automatic int val_at(input int c);
    foreach (pq_cyc[i]) if (pq_cyc[i] == c) return pq_val[i];
    return -1;
  endfunction

  function automatic int cnt_p(input int lo, input int hi);
    int r = 0;
    foreach (pq_cyc[i]) if (pq_cyc[i] > lo && pq_cyc[i] < hi) r++;
    return r;
  endfunction

  function automatic int cnt_e(input int lo, input int hi);
    int r = 0;
    foreach (eq_cyc[i]) if (eq_cyc[i] > lo && eq_cyc[i] < hi) r++;
    return r;
  endfunction

  task automatic seg(input int len, input int duty, input bit sy, input int glitch, output int last);
    for (int p = 0; p < len; p++) begin
      bus.frame_sync = sy && (p == 0);
      bus.pwm_in     = (p < duty) || (p == glitch);
      @(posedge MCLK);
      #1;
    end
    bus.frame_sync = 1'b0;
    bus.pwm_in     = 1'b0;
    last = cyc;
  endtask

  task automatic idle(input int k);
    bus.frame_sync = 1'b0;
    bus.pwm_in     = 1'b0;
    repeat (k) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  int e7a, e_r0, e_r1, e_x0, e_y0, e_g, r_cyc, tmp, m_end;
  int e_s[5];
  int e_m[5];
  int sweep[5] = '{0, 1, 8, 15, 16};

  initial begin
    MRST = 1'b1;
    bus.pwm_in = 1'b0;
    bus.frame_sync = 1'b0;
    idle(4);
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    MRST = 1'b0;
    idle(3);

    seg(FL, 7, 1'b1, -1, e7a);
    for (int i = 0; i < 3; i++) seg(FL, 7, 1'b1, -1, tmp);
    chk("lit_locked_after_lock", bus.locked, 1);

    for (int i = 0; i < 5; i++) seg(FL, sweep[i], 1'b1, -1, e_s[i]);

    for (int i = 0; i < 5; i++) seg(FL, 3, 1'b0, -1, e_m[i]);
    idle(5);
    m_end = cyc;
    chk("lit_locked_after_miss", bus.locked, 0);

    seg(FL, 5, 1'b1, -1, e_r0);
    seg(5, 5, 1'b1, -1, tmp);
    seg(FL, 9, 1'b1, -1, e_r1);
    seg(FL, 9, 1'b1, -1, tmp);

    seg(FL, 4, 1'b1, -1, e_x0);
    seg(9, 4, 1'b1, -1, tmp);
    MRST = 1'b1;
    bus.pwm_in = 1'b1;
    @(posedge MCLK);
    #1;
    r_cyc = cyc;
    chk("midrst_dout", bus.dout, 0);
    chk("midrst_valid", bus.dout_valid, 0);
    chk("midrst_locked", bus.locked, 0);
    chk("midrst_sync_err", bus.sync_err, 0);
    MRST = 1'b0;
    idle(20);
    seg(FL, 6, 1'b1, -1, e_y0);
    seg(FL, 6, 1'b1, -1, tmp);

    seg(FL, 6, 1'b1, 10, e_g);
    seg(FL, 6, 1'b1, -1, tmp);
    idle(8);

    chk("lit_latency_gap", cnt_p(e7a - FL, e7a + D), 0);
    chk("lit_first_dout7", val_at(e7a + D), 7);
    chk("lit_sweep0", val_at(e_s[0] + D), 0);
    chk("lit_sweep1", val_at(e_s[1] + D), FILT ? 0 : 1);
    chk("lit_sweep8", val_at(e_s[2] + D), 8);
    chk("lit_sweep15", val_at(e_s[3] + D), 15);
    chk("lit_saturate", val_at(e_s[4] + D), 15);
    chk("lit_miss_pulses", cnt_p(e_s[4] + D, m_end + 1), 2);
    chk("lit_miss_dout", val_at(e_m[0] + D), 3);
    chk("lit_relock_dout", val_at(e_r0 + D), 5);
    chk("lit_sync_err_count", cnt_e(e_r0, e_r1), 1);
    chk("lit_trunc_no_valid", cnt_p(e_r0 + D, e_r1 + D), 0);
    chk("lit_after_err_dout", val_at(e_r1 + D), 9);
    chk("lit_pre_rst_dout", val_at(e_x0 + D), 4);
    chk("lit_rst_no_valid", cnt_p(r_cyc - 1, e_y0 + D), 0);
    chk("lit_post_rst_dout", val_at(e_y0 + D), 6);
    chk("lit_glitch", val_at(e_g + D), FILT ? 6 : 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
